// File: rtl/branch_cond_unit_pkg.sv
// Shared definitions for the branch condition unit: branch types, flag bit
// positions and shadow FSM state encoding.
package branch_cond_unit_pkg;

  localparam int unsigned BR_TYPE_W = 3;
  localparam int unsigned FLAG_W    = 4;

  localparam logic [BR_TYPE_W-1:0] BR_JZ   = 3'd0;
  localparam logic [BR_TYPE_W-1:0] BR_JN   = 3'd1;
  localparam logic [BR_TYPE_W-1:0] BR_JC   = 3'd2;
  localparam logic [BR_TYPE_W-1:0] BR_JV   = 3'd3;
  localparam logic [BR_TYPE_W-1:0] BR_JMP  = 3'd4;
  localparam logic [BR_TYPE_W-1:0] BR_CALL = 3'd5;

  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_V = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_ISR = 1'b1
  } shadow_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition decode: picks the tested flag for a branch
// type and reports which flag bit a taken conditional jump would clear.
module branch_cond_eval
  import branch_cond_unit_pkg::*;
(
  input  logic [BR_TYPE_W-1:0] br_type,
  input  logic [FLAG_W-1:0]    ccr_in,
  output logic                 cond,
  output logic [FLAG_W-1:0]    clr_mask
);

  always_comb begin
    cond     = 1'b0;
    clr_mask = '0;
    case (br_type)
      BR_JZ: begin
        cond            = ccr_in[FLG_Z];
        clr_mask[FLG_Z] = 1'b1;
      end
      BR_JN: begin
        cond            = ccr_in[FLG_N];
        clr_mask[FLG_N] = 1'b1;
      end
      BR_JC: begin
        cond            = ccr_in[FLG_C];
        clr_mask[FLG_C] = 1'b1;
      end
      BR_JV: begin
        cond            = ccr_in[FLG_V];
        clr_mask[FLG_V] = 1'b1;
      end
      BR_JMP, BR_CALL: cond = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch resolution and flag write-back unit. Define BRANCH_FLAG_CLR_EN to
// make taken conditional jumps clear the flag they tested.
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLAG_W-1:0]    ccr_in,
  input  logic                 br_valid,
  input  logic [BR_TYPE_W-1:0] br_type,
  input  logic [ADDR_W-1:0]    br_target,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 int_save,
  input  logic                 rti_restore,
  output logic                 take_o,
  output logic [ADDR_W-1:0]    target_o,
  output logic                 ccr_wr_en,
  output logic [FLAG_W-1:0]    ccr_wr_data,
  output logic                 in_isr_o
);

  shadow_state_e     state, state_d;
  logic [FLAG_W-1:0] shadow, shadow_d;
  logic              take_d;
  logic [ADDR_W-1:0] target_d;
  logic              wr_en_d;
  logic [FLAG_W-1:0] wr_data_d;
  logic              in_isr_d;
  logic              cond;
  logic [FLAG_W-1:0] clr_mask;
  logic              taken;

  branch_cond_eval u_eval (
    .br_type  (br_type),
    .ccr_in   (ccr_in),
    .cond     (cond),
    .clr_mask (clr_mask)
  );

  assign taken = br_valid & ~stall & ~flush & cond;

`ifndef BRANCH_FLAG_CLR_EN
  logic unused_clr;
  assign unused_clr = ^clr_mask;
`endif

  // State and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      shadow      <= '0;
      take_o      <= 1'b0;
      target_o    <= '0;
      ccr_wr_en   <= 1'b0;
      ccr_wr_data <= '0;
      in_isr_o    <= 1'b0;
    end else begin
      state       <= state_d;
      shadow      <= shadow_d;
      take_o      <= take_d;
      target_o    <= target_d;
      ccr_wr_en   <= wr_en_d;
      ccr_wr_data <= wr_data_d;
      in_isr_o    <= in_isr_d;
    end
  end

  // Decision, flag clear and shadow FSM; a restore write is assigned last so
  // it overrides any clear in the same cycle.
  always_comb begin
    state_d   = state;
    shadow_d  = shadow;
    take_d    = 1'b0;
    target_d  = target_o;
    wr_en_d   = 1'b0;
    wr_data_d = '0;

    if (taken) begin
      take_d   = 1'b1;
      target_d = br_target;
    end

`ifdef BRANCH_FLAG_CLR_EN
    if (taken && (|clr_mask)) begin
      wr_en_d   = 1'b1;
      wr_data_d = ccr_in & ~clr_mask;
    end
`endif

    case (state)
      ST_IDLE: begin
        if (int_save) begin
          shadow_d = ccr_in;
          state_d  = ST_IN_ISR;
        end
      end
      ST_IN_ISR: begin
        if (rti_restore) begin
          wr_en_d   = 1'b1;
          wr_data_d = shadow;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_isr_d = (state_d == ST_IN_ISR);
  end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: directed vector table, an async
// reset sequence, and random traffic against a behavioural model.
module tb_branch_cond_unit;

`ifdef BRANCH_FLAG_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ccr_in;
  logic       br_valid;
  logic [2:0] br_type;
  logic [7:0] br_target;
  logic       stall, flush, int_save, rti_restore;
  logic       take_o;
  logic [7:0] target_o;
  logic       ccr_wr_en;
  logic [3:0] ccr_wr_data;
  logic       in_isr_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_cond_unit #(.ADDR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ccr_in      (ccr_in),
    .br_valid    (br_valid),
    .br_type     (br_type),
    .br_target   (br_target),
    .stall       (stall),
    .flush       (flush),
    .int_save    (int_save),
    .rti_restore (rti_restore),
    .take_o      (take_o),
    .target_o    (target_o),
    .ccr_wr_en   (ccr_wr_en),
    .ccr_wr_data (ccr_wr_data),
    .in_isr_o    (in_isr_o)
  );

  typedef struct {
    logic       valid;
    logic [2:0] typ;
    logic [7:0] tgt;
    logic [3:0] ccr;
    logic       stall;
    logic       flush;
    logic       save;
    logic       rti;
    logic       e_take;
    logic [7:0] e_tgt;
    logic       e_wr_on;
    logic       e_wr_off;
    logic [3:0] e_data;
    logic       e_isr;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] t, input logic [7:0] tg,
                       input logic [3:0] c, input logic s, input logic f,
                       input logic sv, input logic r);
    br_valid = v; br_type = t; br_target = tg; ccr_in = c;
    stall = s; flush = f; int_save = sv; rti_restore = r;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 3'd0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Behavioural reference: branch type 0..3 tests flag bit of the same index.
  logic       m_isr;
  logic [3:0] m_shadow;
  logic [7:0] m_target;

  task automatic model_cycle(output logic e_take, output logic e_wr, output logic [3:0] e_data);
    logic c;
    c = (br_type < 3'd4) ? ccr_in[br_type] : (br_type < 3'd6);
    e_take = br_valid && !stall && !flush && c;
    e_wr = 1'b0;
    e_data = 4'h0;
    if (e_take) m_target = br_target;
    if (CLR_EN && e_take && br_type < 3'd4) begin
      e_wr = 1'b1;
      e_data = ccr_in & ~(4'b0001 << br_type);
    end
    if (m_isr) begin
      if (rti_restore) begin
        e_wr = 1'b1;
        e_data = m_shadow;
        m_isr = 1'b0;
      end
    end else if (int_save) begin
      m_shadow = ccr_in;
      m_isr = 1'b1;
    end
  endtask

  initial begin
    logic       e_take, e_wr;
    logic [3:0] e_data;
    vecs[0]  = '{1'b1, 3'd0, 8'h3C, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 4'b0000, 1'b0};
    vecs[1]  = '{1'b1, 3'd2, 8'h55, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[2]  = '{1'b1, 3'd4, 8'h77, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[3]  = '{1'b1, 3'd1, 8'h11, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[4]  = '{1'b1, 3'd1, 8'h11, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[5]  = '{1'b1, 3'd1, 8'h11, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 4'b0000, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[7]  = '{1'b0, 3'd0, 8'h00, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[8]  = '{1'b1, 3'd3, 8'h9A, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h9A, 1'b1, 1'b1, 4'b0110, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h9A, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[10] = '{1'b1, 3'd6, 8'h5A, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h9A, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[11] = '{1'b1, 3'd5, 8'h20, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[12] = '{1'b1, 3'd3, 8'h21, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 1'b1, 1'b0, 4'b0000, 1'b0};
    vecs[13] = '{1'b1, 3'd0, 8'h22, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h21, 1'b0, 1'b0, 4'b0000, 1'b0};
    vecs[14] = '{1'b1, 3'd2, 8'h30, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h30, 1'b1, 1'b0, 4'b0000, 1'b1};
    vecs[15] = '{1'b0, 3'd0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 1'b1, 1'b1, 4'b0100, 1'b0};

    do_reset();
    chk("reset take_o", 32'(take_o), 32'd0);
    chk("reset target_o", 32'(target_o), 32'd0);
    chk("reset ccr_wr_en", 32'(ccr_wr_en), 32'd0);
    chk("reset ccr_wr_data", 32'(ccr_wr_data), 32'd0);
    chk("reset in_isr_o", 32'(in_isr_o), 32'd0);

    // Directed vector table, state carried from row to row.
    for (int i = 0; i < 16; i++) begin
      logic exp_wr;
      drive(vecs[i].valid, vecs[i].typ, vecs[i].tgt, vecs[i].ccr,
            vecs[i].stall, vecs[i].flush, vecs[i].save, vecs[i].rti);
      step();
      exp_wr = CLR_EN ? vecs[i].e_wr_on : vecs[i].e_wr_off;
      chk($sformatf("vec%0d take_o", i), 32'(take_o), 32'(vecs[i].e_take));
      chk($sformatf("vec%0d target_o", i), 32'(target_o), 32'(vecs[i].e_tgt));
      chk($sformatf("vec%0d ccr_wr_en", i), 32'(ccr_wr_en), 32'(exp_wr));
      if (exp_wr)
        chk($sformatf("vec%0d ccr_wr_data", i), 32'(ccr_wr_data), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d in_isr_o", i), 32'(in_isr_o), 32'(vecs[i].e_isr));
    end
    idle_inputs();
    step();
    chk("pulse take_o", 32'(take_o), 32'd0);
    chk("pulse ccr_wr_en", 32'(ccr_wr_en), 32'd0);

    // Async reset in the middle of an ISR, while a decision is showing.
    drive(1'b1, 3'd4, 8'h44, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    idle_inputs();
    chk("pre-reset take_o", 32'(take_o), 32'd1);
    chk("pre-reset in_isr_o", 32'(in_isr_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async take_o", 32'(take_o), 32'd0);
    chk("async target_o", 32'(target_o), 32'd0);
    chk("async ccr_wr_en", 32'(ccr_wr_en), 32'd0);
    chk("async ccr_wr_data", 32'(ccr_wr_data), 32'd0);
    chk("async in_isr_o", 32'(in_isr_o), 32'd0);
    rst = 1'b0;
    rti_restore = 1'b1;
    step();
    rti_restore = 1'b0;
    chk("post-reset rti ccr_wr_en", 32'(ccr_wr_en), 32'd0);
    chk("post-reset rti in_isr_o", 32'(in_isr_o), 32'd0);

    // Random traffic against the behavioural model.
    do_reset();
    m_isr = 1'b0;
    m_shadow = 4'h0;
    m_target = 8'h00;
    for (int i = 0; i < 400; i++) begin
      br_valid    = ($urandom_range(0, 3) != 0);
      br_type     = 3'($urandom_range(0, 7));
      br_target   = 8'($urandom);
      ccr_in      = 4'($urandom);
      stall       = ($urandom_range(0, 5) == 0);
      flush       = ($urandom_range(0, 5) == 0);
      int_save    = ($urandom_range(0, 6) == 0);
      rti_restore = ($urandom_range(0, 4) == 0);
      model_cycle(e_take, e_wr, e_data);
      step();
      chk("rand take_o", 32'(take_o), 32'(e_take));
      chk("rand target_o", 32'(target_o), 32'(m_target));
      chk("rand ccr_wr_en", 32'(ccr_wr_en), 32'(e_wr));
      if (e_wr) chk("rand ccr_wr_data", 32'(ccr_wr_data), 32'(e_data));
      chk("rand in_isr_o", 32'(in_isr_o), 32'(m_isr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Consumer of the condition-code register: samples the stored {V,C,N,Z} flags, resolves conditional and unconditional branches from the decode stage, and issues a registered take/target decision to fetch. Also writes back to the flag register: it clears the tested flag after a taken conditional jump, and it saves and restores the flags across a single-level interrupt. Sits between the flag register, decode, and the PC-select logic.

## Interface
- ADDR_W, 8, width of branch target / PC
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ccr_in  in  4  current flags {V,C,N,Z}; bit0=Z, bit1=N, bit2=C, bit3=V
- br_valid  in  1  branch instruction present in decode
- br_type  in  3  0=JZ, 1=JN, 2=JC, 3=JV, 4=JMP, 5=CALL, 6–7 reserved (never taken)
- br_target  in  ADDR_W  branch destination
- stall  in  1  pipeline stall; inputs not sampled this cycle
- flush  in  1  kill in-flight decision
- int_save  in  1  interrupt entry; snapshot flags
- rti_restore  in  1  return-from-interrupt; restore snapshot
- take_o  out  1  registered branch-taken pulse
- target_o  out  ADDR_W  registered target, valid while take_o=1
- ccr_wr_en  out  1  flag-register write strobe
- ccr_wr_data  out  4  value to write into flag register
- in_isr_o  out  1  shadow holds a saved snapshot

## Operation
- Condition: JZ→Z, JN→N, JC→C, JV→V, JMP/CALL→1, reserved→0. Evaluated on ccr_in at the sampling edge.
- Sample cycle: br_valid=1 and stall=0 and flush=0.
- Taken on a sample cycle: take_o=1 and target_o=br_target for exactly one cycle.
- Otherwise take_o=0. target_o holds its last value.
- Flag clear (see Configuration): a taken JZ/JN/JC/JV issues ccr_wr_en=1 with ccr_wr_data = ccr_in & ~mask, where mask is the tested bit. ccr_in is the value sampled at the decision edge. Issued in the same cycle as take_o.
- Shadow FSM, 2 states:
  - IDLE → IN_ISR on int_save: shadow ← ccr_in.
  - IN_ISR → IDLE on rti_restore: ccr_wr_en=1, ccr_wr_data=shadow for one cycle.
  - int_save in IN_ISR is ignored (no nesting).
  - rti_restore in IDLE is ignored; no write is issued.
- int_save and rti_restore are not gated by stall or flush.
- Write priority: a restore write overrides a flag-clear write in the same cycle; the clear is dropped.
- Simultaneous int_save and taken conditional in IDLE: shadow captures the pre-clear ccr_in.

## Timing
- Decision latency: 1 cycle. Inputs sampled at edge N; take_o, target_o and the clear write are visible after edge N.
- Restore latency: 1 cycle. rti_restore at edge N → ccr_wr_en high during cycle N+1.
- ccr_wr_en is a single-cycle pulse. The flag register applies it at the next edge.
- Back-to-back sample cycles produce back-to-back decisions.
- flush at edge N: forces take_o=0 and drops any clear write after edge N. Has no effect on the FSM.
- Reset (async, any time): take_o=0, target_o=0, ccr_wr_en=0, ccr_wr_data=0, shadow=0, state=IDLE, in_isr_o=0. A pending restore is lost.

## Configuration
- BRANCH_FLAG_CLR_EN defined: taken conditional jumps clear the tested flag as described above.
- BRANCH_FLAG_CLR_EN undefined: no clear writes; ccr_wr_en is driven only by rti_restore. Branch decisions are unchanged.

## Structure
- Shared package holds:
  - br_type localparams (BR_JZ … BR_CALL)
  - flag bit indices (FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3)
  - FSM state encoding
- One sub-module: branch_cond_eval, combinational; (br_type, ccr_in) → cond, clr_mask.

## Test plan
- Reset asserted mid-ISR with shadow=4'b1010 → all outputs 0, in_isr_o=0; a following rti_restore issues no write.
- ccr_in=4'b0001, JZ to 8'h3C → next cycle take_o=1, target_o=8'h3C, ccr_wr_en=1, ccr_wr_data=4'b0000 (macro on); ccr_wr_en=0 with macro off.
- ccr_in=4'b0000, JC → take_o=0, ccr_wr_en=0. JMP with ccr_in=0 → take_o=1, no clear write.
- JN taken with stall=1 → no decision; same JN taken with flush=1 → take_o=0, no write.
- int_save with ccr_in=4'b0110, then rti_restore → ccr_wr_en=1, ccr_wr_data=4'b0110, in_isr_o falls; a second int_save while in ISR leaves the shadow unchanged.
- rti_restore in the same cycle as a taken JV (ccr_in=4'b1000) → take_o=1, ccr_wr_data=shadow (the clear is dropped).
